// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    // Width of one BCD digit.
    localparam int BCD_W = 4;

    // Controller state encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Per-digit correction step of shift-and-add-3: digits of 5 or more get 3
// added so the following left shift carries correctly into the next digit.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [BCD_W-1:0] din,
    output logic [BCD_W-1:0] dout
);

    // Add 3 to any digit that would reach 10 or more after doubling.
    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock, with a
// start/busy/done handshake. Results that exceed DIGITS decimal digits are
// truncated to the low digits and flagged through overflow.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [WIDTH-1:0]          bin,
    output logic                      busy,
    output logic                      done,
    output logic [BCD_W*DIGITS-1:0]   bcd,
    output logic                      overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int BCD_BITS = BCD_W * DIGITS;

    state_t                state;
    logic [WIDTH-1:0]      shift_reg;
    logic [BCD_BITS-1:0]   scratch_bcd;
    logic                  scratch_ovf;
    logic [CNT_W-1:0]      bit_cnt;

    logic [BCD_BITS-1:0]   adj_bcd;
    logic [BCD_BITS-1:0]   next_bcd;
    logic [WIDTH-1:0]      next_shift;
    logic                  next_ovf;

    // One add-3 corrector per digit of the scratch BCD register.
    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scratch_bcd[k*BCD_W +: BCD_W]),
            .dout (adj_bcd[k*BCD_W +: BCD_W])
        );
    end

    // Corrected digits and shift register shifted left as one long word; the
    // bit leaving the top digit means the value no longer fits.
    always_comb begin
        next_bcd   = {adj_bcd[BCD_BITS-2:0], shift_reg[WIDTH-1]};
        next_shift = {shift_reg[WIDTH-2:0], 1'b0};
        next_ovf   = scratch_ovf | adj_bcd[BCD_BITS-1];
    end

    // Controller: accepts a start in IDLE, shifts WIDTH times, then pulses
    // done for one cycle while publishing the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            shift_reg   <= '0;
            scratch_bcd <= '0;
            scratch_ovf <= 1'b0;
            bit_cnt     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            bcd         <= '0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        shift_reg   <= bin;
                        scratch_bcd <= '0;
                        scratch_ovf <= 1'b0;
                        bit_cnt     <= CNT_W'(WIDTH);
                        busy        <= 1'b1;
                        state       <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    shift_reg   <= next_shift;
                    scratch_bcd <= next_bcd;
                    scratch_ovf <= next_ovf;
                    bit_cnt     <= bit_cnt - CNT_W'(1);
                    if (bit_cnt == CNT_W'(1)) begin
                        bcd      <= next_bcd;
                        overflow <= next_ovf;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq: a default 16-bit/5-digit
// instance and an 8-bit/2-digit instance for the overflow cases.
module tb_bin2bcd_seq;

    logic        clk;
    logic        reset;

    logic        start;
    logic [15:0] bin;
    logic        busy;
    logic        done;
    logic [19:0] bcd;
    logic        overflow;

    logic        start8;
    logic [7:0]  bin8;
    logic        busy8;
    logic        done8;
    logic [7:0]  bcd8;
    logic        overflow8;

    int tests_run;
    int tests_failed;

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .overflow (overflow)
    );

    bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) u_dut8 (
        .clk      (clk),
        .reset    (reset),
        .start    (start8),
        .bin      (bin8),
        .busy     (busy8),
        .done     (done8),
        .bcd      (bcd8),
        .overflow (overflow8)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse start for one cycle; returns at the falling edge after the
    // accepting rising edge.
    task automatic do_start(input logic [15:0] value);
        @(negedge clk);
        start = 1'b1;
        bin   = value;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done on the 16-bit instance, counting cycles and
    // busy cycles seen before it.
    task automatic wait_done(output int cycles, output int busy_cycles, output bit seen);
        cycles      = 0;
        busy_cycles = 0;
        seen        = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        bin   = 16'd123;
        start8 = 1'b1;
        bin8   = 8'd200;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl: busy=%b done=%b, required 0 0", busy, done);
        end
        tests_run++;
        if (bcd !== 20'h00000 || overflow !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data: bcd=%h ovf=%b, required 00000 0", bcd, overflow);
        end
        tests_run++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || bcd8 !== 8'h00 || overflow8 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_small: busy=%b done=%b bcd=%h ovf=%b, required 0 0 00 0",
                     busy8, done8, bcd8, overflow8);
        end
        reset  = 1'b0;
        start  = 1'b0;
        start8 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero();
        int  cyc;
        int  bcyc;
        bit  seen;
        do_start(16'd0);
        wait_done(cyc, bcyc, seen);
        tests_run++;
        if (!seen || cyc !== 16) begin
            tests_failed++;
            $display("[TB] FAIL zero_latency: seen=%b cycles=%0d, required 1 16", seen, cyc);
        end
        tests_run++;
        if (bcyc !== 16) begin
            tests_failed++;
            $display("[TB] FAIL zero_busy: busy cycles=%0d, required 16", bcyc);
        end
        tests_run++;
        if (busy !== 1'b0 || bcd !== 20'h00000 || overflow !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL zero_result: busy=%b bcd=%h ovf=%b, required 0 00000 0", busy, bcd, overflow);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL zero_pulse: done=%b busy=%b after pulse, required 0 0", done, busy);
        end
    endtask

    task automatic test_values();
        logic [15:0] vin  [4] = '{16'd1234, 16'd65535, 16'd9999, 16'd10000};
        logic [19:0] vexp [4] = '{20'h01234, 20'h65535, 20'h09999, 20'h10000};
        int  cyc;
        int  bcyc;
        bit  seen;
        for (int i = 0; i < 4; i++) begin
            do_start(vin[i]);
            wait_done(cyc, bcyc, seen);
            tests_run++;
            if (!seen || bcd !== vexp[i] || overflow !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL value_%0d: seen=%b bcd=%h ovf=%b, required 1 %h 0",
                         vin[i], seen, bcd, overflow, vexp[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_start();
        int dones;
        do_start(16'd42);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 4) begin
                start = 1'b1;
                bin   = 16'd7;
            end else if (i == 5) begin
                start = 1'b0;
            end
            if (done) begin
                dones++;
                tests_run++;
                if (bcd !== 20'h00042) begin
                    tests_failed++;
                    $display("[TB] FAIL ignore_result: bcd=%h, required 00042", bcd);
                end
            end
            @(negedge clk);
        end
        tests_run++;
        if (dones !== 1) begin
            tests_failed++;
            $display("[TB] FAIL ignore_count: done pulses=%0d, required 1", dones);
        end
    endtask

    task automatic test_reset_abort();
        int  dones;
        int  cyc;
        int  bcyc;
        bit  seen;
        do_start(16'd999);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd !== 20'h00000 || overflow !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_state: busy=%b done=%b bcd=%h ovf=%b, required 0 0 00000 0",
                     busy, done, bcd, overflow);
        end
        dones = 0;
        for (int i = 0; i < 24; i++) begin
            if (done || busy) dones++;
            @(negedge clk);
        end
        tests_run++;
        if (dones !== 0) begin
            tests_failed++;
            $display("[TB] FAIL abort_quiet: active cycles=%0d, required 0", dones);
        end
        do_start(16'd999);
        wait_done(cyc, bcyc, seen);
        tests_run++;
        if (!seen || bcd !== 20'h00999 || overflow !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_rerun: seen=%b bcd=%h ovf=%b, required 1 00999 0", seen, bcd, overflow);
        end
        @(negedge clk);
    endtask

    task automatic test_small_width();
        logic [7:0] vin  [3] = '{8'd255, 8'd99, 8'd100};
        logic [7:0] vexp [3] = '{8'h55, 8'h99, 8'h00};
        logic       oexp [3] = '{1'b1, 1'b0, 1'b1};
        bit         seen;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start8 = 1'b1;
            bin8   = vin[i];
            @(negedge clk);
            start8 = 1'b0;
            seen = 1'b0;
            for (int j = 0; j < 20; j++) begin
                if (done8) begin
                    seen = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            tests_run++;
            if (!seen || bcd8 !== vexp[i] || overflow8 !== oexp[i]) begin
                tests_failed++;
                $display("[TB] FAIL small_%0d: seen=%b bcd=%h ovf=%b, required 1 %h %b",
                         vin[i], seen, bcd8, overflow8, vexp[i], oexp[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int  cyc;
        int  bcyc;
        bit  seen;
        int  held_bad;
        do_start(16'd1234);
        wait_done(cyc, bcyc, seen);
        tests_run++;
        if (!seen || bcd !== 20'h01234) begin
            tests_failed++;
            $display("[TB] FAIL b2b_first: seen=%b bcd=%h, required 1 01234", seen, bcd);
        end
        @(negedge clk);
        start = 1'b1;
        bin   = 16'd65535;
        @(negedge clk);
        start = 1'b0;
        bin   = 16'd0;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_accept: busy=%b, required 1", busy);
        end
        held_bad = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (bcd !== 20'h01234) held_bad++;
            @(negedge clk);
        end
        tests_run++;
        if (held_bad !== 0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_hold: cycles with changed bcd=%0d, required 0", held_bad);
        end
        tests_run++;
        if (!seen || bcd !== 20'h65535 || overflow !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_second: seen=%b bcd=%h ovf=%b, required 1 65535 0", seen, bcd, overflow);
        end
        @(negedge clk);
    endtask

    // Test sequence.
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset  = 1'b1;
        start  = 1'b0;
        bin    = '0;
        start8 = 1'b0;
        bin8   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        test_reset();
        test_zero();
        test_values();
        test_ignore_start();
        test_reset_abort();
        test_small_width();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
